// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: six-state ring counter plus opcode decode
// into the 12-bit control word, with a sticky HLT state cleared only by CLR.
module sap1_controller_sequencer (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm_bar,
    output logic       CE_bar,
    output logic       Li_bar,
    output logic       Ei_bar,
    output logic       La_bar,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb_bar,
    output logic       Lo_bar,
    output logic [5:0] t_state,
    output logic       hlt
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   halted;
    logic   halted_nxt;
    logic   hlt_now;

    // Ring counter and halted flag
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= T1;
            halted <= 1'b0;
        end else begin
            state  <= state_nxt;
            halted <= halted_nxt;
        end
    end

    // Next state and control-word decode of (state, opcode, halted)
    always_comb begin
        state_nxt  = state;
        halted_nxt = halted;
        hlt_now    = halted || ((state == T4) && (opcode == OP_HLT));
        t_state    = state;
        hlt        = hlt_now;
        Cp         = 1'b0;
        Ep         = 1'b0;
        Lm_bar     = 1'b1;
        CE_bar     = 1'b1;
        Li_bar     = 1'b1;
        Ei_bar     = 1'b1;
        La_bar     = 1'b1;
        Ea         = 1'b0;
        Su         = 1'b0;
        Eu         = 1'b0;
        Lb_bar     = 1'b1;
        Lo_bar     = 1'b1;

        if (hlt_now) begin
            halted_nxt = 1'b1;
        end else begin
            case (state)
                T1:      state_nxt = T2;
                T2:      state_nxt = T3;
                T3:      state_nxt = T4;
                T4:      state_nxt = T5;
                T5:      state_nxt = T6;
                T6:      state_nxt = T1;
                default: state_nxt = T1;
            endcase

            case (state)
                T1: begin
                    Ep     = 1'b1;
                    Lm_bar = 1'b0;
                end
                T2: Cp = 1'b1;
                T3: begin
                    CE_bar = 1'b0;
                    Li_bar = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            Lm_bar = 1'b0;
                            Ei_bar = 1'b0;
                        end
                        OP_OUT: begin
                            Ea     = 1'b1;
                            Lo_bar = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            CE_bar = 1'b0;
                            La_bar = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            CE_bar = 1'b0;
                            Lb_bar = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                        La_bar = 1'b0;
                        Eu     = 1'b1;
                        Su     = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sap1_controller_sequencer.md
# sap1_controller_sequencer

Control unit of the SAP-1 datapath and consumer of the instruction register's opcode field. A six-state ring counter (T1–T6) steps through fetch and execute. Each state, combined with the current 4-bit opcode, is decoded into the 12-bit control word that drives the program counter, MAR, RAM, instruction register, accumulator, ALU, B register and output register. HLT freezes the sequencer until reset.

## Interface
- No parameters; opcode encodings are fixed: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111.
- CLK  in  1  system clock; all state changes on rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- opcode  in  4  opcode field from the instruction register (ungated latch contents, not the tri-stated path); must be valid and stable from start of T4 to end of T6.
- Cp  out  1  PC increment (active-high).
- Ep  out  1  PC onto bus (active-high).
- Lm_bar  out  1  MAR load (active-low).
- CE_bar  out  1  RAM onto bus (active-low).
- Li_bar  out  1  IR load (active-low).
- Ei_bar  out  1  IR address field onto bus (active-low).
- La_bar  out  1  accumulator load (active-low).
- Ea  out  1  accumulator onto bus (active-high).
- Su  out  1  ALU subtract select (active-high).
- Eu  out  1  ALU onto bus (active-high).
- Lb_bar  out  1  B register load (active-low).
- Lo_bar  out  1  output register load (active-low).
- t_state  out  6  one-hot ring state; bit0=T1 … bit5=T6.
- hlt  out  1  halted indicator (active-high); gates the system clock externally.

## Operation
- Inactive word (NOP): Cp=Ep=Ea=Su=Eu=0; all *_bar=1.
- Any signal not listed for a state is at its inactive level.
- Fetch (all opcodes):
  - T1: Ep=1, Lm_bar=0.
  - T2: Cp=1.
  - T3: CE_bar=0, Li_bar=0.
- LDA:
  - T4: Lm_bar=0, Ei_bar=0.
  - T5: CE_bar=0, La_bar=0.
  - T6: NOP.
- ADD:
  - T4: Lm_bar=0, Ei_bar=0.
  - T5: CE_bar=0, Lb_bar=0.
  - T6: La_bar=0, Eu=1.
- SUB: same as ADD, plus Su=1 in T6.
- OUT:
  - T4: Ea=1, Lo_bar=0.
  - T5, T6: NOP.
- HLT, in T4:
  - Control word is NOP.
  - hlt=1 combinationally.
  - Ring counter does not advance.
  - Internal halted flag sets on that rising edge.
- Halted:
  - Ring counter stays in T4.
  - hlt=1, control word is NOP, regardless of later opcode changes.
  - Exit only via CLR.
- Undefined opcodes (0011–1101): T4–T6 are NOP; sequencing continues normally.
- Control word is a combinational decode of (t_state, opcode, halted). Opcode is ignored in T1–T3.
- Ring counter: T1→T2→…→T6→T1, one step per rising edge when not halted.
- Ring counter is one-hot by construction; no other encodings are reachable.

## Timing
- CLR asserted:
  - t_state=000001 and halted=0, immediately and asynchronously.
  - Outputs show the T1 word (Ep=1, Lm_bar=0, rest inactive) and hlt=0.
- CLR deasserted: the first rising edge moves T1→T2.
- An instruction takes 6 cycles. The control word for Tn is valid for the whole cycle, and the datapath latches on the rising edge ending Tn.
- An opcode change during T4–T6 changes the control word in the same cycle; the source must hold opcode stable over that window.
- HLT timing:
  - hlt rises in the T4 cycle (combinational).
  - It is held by the flag from the next edge onward.
  - It stays high if opcode later changes.
- CLR mid-instruction or while halted: immediate return to T1 with halted cleared; no partial state is retained.

## Test plan
- Reset: assert CLR mid-T5 of ADD -> t_state=000001, Ep=1, Lm_bar=0, hlt=0 immediately. Release CLR -> next edge gives t_state=000010, Cp=1.
- LDA, opcode=0000, cycle through T1–T6. Check per state:
  - T1: Ep=1, Lm_bar=0.
  - T2: Cp=1.
  - T3: CE_bar=0, Li_bar=0.
  - T4: Lm_bar=0, Ei_bar=0.
  - T5: CE_bar=0, La_bar=0.
  - T6: NOP.
  - Then back to t_state=000001.
- ADD/SUB: opcode=0001, then 0010.
  - T5: CE_bar=0, Lb_bar=0.
  - T6: La_bar=0, Eu=1; Su=0 for ADD, Su=1 for SUB.
- OUT: opcode=1110 -> T4 shows Ea=1, Lo_bar=0; T5 and T6 NOP.
- Undefined opcode: opcode=0101 -> T4–T6 NOP, normal wrap to T1.
- HLT: opcode=1111.
  - T4: hlt=1, control word NOP.
  - 10 further edges: t_state stays 001000, hlt=1.
  - opcode changed to 0000 -> still halted.
  - CLR -> T1, hlt=0.
